counter_checker: RTL and testbench
==================================

// Module: counter_checker
// PURPOSE
//  Passive scoreboard on the counter's output side. It reads the same control inputs the counter sees,
//  predicts the next cout, and compares every cycle. Mismatches are flagged and counted, and the first
//  failure is captured. Sits beside the counter in the bench and in the FPGA self-test wrapper.
// PARAMETERS
//  WIDTH        8   counter/cout width; arithmetic is modulo 2**WIDTH
//  PL_WIDTH     4   pl_data width; zero-extended to WIDTH on preload
//  ERRCNT_W     16  width of err_cnt and chk_cnt (both saturate)
//  STOP_ON_ERR  0   1: enter HALT on the first mismatch; 0: resync and continue
// PORTS
//  clk          in   1          single clock; all state updates on posedge
//  reset        in   1          synchronous, active-high
//  enable       in   1          counter enable, as driven to the counter
//  updn         in   1          1 = count up, 0 = count down
//  preload      in   1          load pl_data (priority over enable)
//  pl_data      in   PL_WIDTH   preload value
//  cout         in   WIDTH      counter output under check
//  exp_val      out  WIDTH      predicted value for the current cycle
//  mismatch     out  1          1-cycle pulse, registered
//  err_cnt      out  ERRCNT_W   number of mismatches
//  chk_cnt      out  ERRCNT_W   number of compares performed
//  first_exp    out  WIDTH      exp_val at the first mismatch
//  first_obs    out  WIDTH      cout at the first mismatch
//  tracking     out  1          high while state == TRACK
//  halted       out  1          high while state == HALT
// BEHAVIOUR
//  - Reset (sync, high): state=SYNC; exp_val=0; mismatch=0; err_cnt=0; chk_cnt=0; first_*=0;
//    tracking=0; halted=0. Reset has priority over all else. Reset mid-run clears everything.
//  - Prediction, evaluated at every edge outside reset and HALT:
//    - preload: nxt = {0, pl_data}
//    - else if enable: nxt = updn ? exp_val+1 : exp_val-1, wrapping (8'hFF+1 = 8'h00, 8'h00-1 = 8'hFF)
//    - else: nxt = exp_val
//    - preload together with enable: preload wins.
//  - Compare at each edge in SYNC or TRACK: the current cout is checked against exp_val.
//    - chk_cnt increments.
//    - On inequality, mismatch is high for exactly the next cycle.
//  - States:
//    - SYNC: entered from reset. At the first non-reset edge, cout must equal 0 (the counter's reset
//      value). The state then goes to TRACK, whether or not that compare matched.
//    - TRACK: compares every edge.
//      - On a mismatch with STOP_ON_ERR=0: exp_val is resynced to the predicted value from the
//        observed cout, so one counter fault causes one error, not a cascade.
//      - On a mismatch with STOP_ON_ERR=1: go to HALT.
//    - HALT: exp_val, err_cnt and chk_cnt are frozen; mismatch=0; leave only via reset.
//  - Prediction source per case:
//    - No mismatch: exp_val <= nxt.
//    - Mismatch in TRACK, STOP_ON_ERR=0: exp_val <= prediction computed from cout instead of exp_val.
//    - Preload is independent of the compared value, so a preload always loads pl_data.
//  - First failure: first_exp/first_obs are captured only when err_cnt==0. They hold until reset.
//  - Saturation: err_cnt and chk_cnt stop at all-ones and never wrap.
//  - Latency: cout sampled at edge k is reported on mismatch and err_cnt after edge k (1 cycle).
//  - Inputs are treated as sampled at the same edges as the counter. No X-checking is done on inputs.
// STRUCTURE
//  - Package counter_pkg:
//    - WIDTH/PL_WIDTH defaults
//    - state encoding: SYNC=2'd0, TRACK=2'd1, HALT=2'd2
//    - function cnt_next(cur, enable, updn, preload, pl_data), shared with the counter's own
//      assertions
//  - One sub-module, counter_model: a combinational next-value predictor wrapping cnt_next,
//    instantiated twice (from exp_val and from cout for resync).
//  - The FSM, compare, and counters live in counter_checker.
// TESTING
//  1. Reset 3 cycles, up-count 26 cycles -> exp_val tracks 0..26, err_cnt=0, chk_cnt=26, tracking=1.
//  2. preload pl_data=5 during up-count -> next cout=5 accepted, no mismatch.
//     preload=1 with enable=1, pl_data=2 -> 2 expected, not an increment.
//  3. Up-count from 8'hFE for 3 cycles -> FF, 00, 01 accepted.
//     updn=0 from 8'h01 -> 00, FF accepted, err_cnt stays 0.
//  4. enable=0 for 10 cycles -> cout constant accepted.
//     Force cout=8'h40 for one cycle where 8'h3C is expected, STOP_ON_ERR=0 ->
//       mismatch pulses once; err_cnt=1; first_exp=3C; first_obs=40; later cycles pass.
//  5. STOP_ON_ERR=1, same fault -> halted=1; err_cnt frozen at 1; further garbage on cout ignored;
//     reset -> all outputs back to reset values, state=SYNC.
//  6. Drive cout=8'h01 at the first edge after reset -> mismatch=1, err_cnt=1, state still TRACK.
//     Force 70000 mismatches -> err_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and its passive checker.
//   - default widths for the counter and its preload port
//   - checker state encoding (kept as plain constants for the legacy netlist)
//   - cnt_next: next-count rule used by the checker's predictors and by the
//     counter's own assertions
package counter_pkg;

  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned PL_WIDTH_DEF = 4;

  // Widest counter cnt_next can model; callers size the result back down,
  // which gives modulo-2**WIDTH wrap for free.
  localparam int unsigned CNT_MAX_W = 32;

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Preload wins over enable; pl_data arrives already zero-extended.
  function automatic logic [CNT_MAX_W-1:0] cnt_next(
    input logic [CNT_MAX_W-1:0] cur,
    input logic                 enable,
    input logic                 updn,
    input logic                 preload,
    input logic [CNT_MAX_W-1:0] pl_data
  );
    logic [CNT_MAX_W-1:0] res;
    res = cur;
    if (preload)
      res = pl_data;
    else if (enable)
      res = updn ? cur + CNT_MAX_W'(1) : cur - CNT_MAX_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/counter_model.sv
// Combinational next-value predictor for the counter.
// Ports:
//   cur      in  WIDTH     value to predict from
//   enable   in  1         counter enable
//   updn     in  1         1 = up, 0 = down
//   preload  in  1         load pl_data (priority over enable)
//   pl_data  in  PL_WIDTH  preload value, zero-extended
//   nxt      out WIDTH     predicted next counter value
module counter_model
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned PL_WIDTH = PL_WIDTH_DEF
) (
  input  logic [WIDTH-1:0]    cur,
  input  logic                enable,
  input  logic                updn,
  input  logic                preload,
  input  logic [PL_WIDTH-1:0] pl_data,
  output logic [WIDTH-1:0]    nxt
);

  // Truncating the wide result back to WIDTH performs the modulo wrap.
  assign nxt = WIDTH'(cnt_next(CNT_MAX_W'(cur), enable, updn, preload,
                               CNT_MAX_W'(pl_data)));

endmodule

// File: rtl/counter_checker.sv
// Passive scoreboard for the up/down counter: predicts the next cout from
// the counter's own control inputs and compares every cycle.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   enable, updn        counter controls as driven to the counter
//   preload, pl_data    counter preload controls
//   cout                counter output under check
//   exp_val             predicted value for the current cycle
//   mismatch            registered one-cycle pulse per failed compare
//   err_cnt, chk_cnt    saturating mismatch / compare counters
//   first_exp/obs       expected / observed values of the first mismatch
//   tracking, halted    state == TRACK / state == HALT
module counter_checker
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned PL_WIDTH    = PL_WIDTH_DEF,
  parameter int unsigned ERRCNT_W    = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                updn,
  input  logic                preload,
  input  logic [PL_WIDTH-1:0] pl_data,
  input  logic [WIDTH-1:0]    cout,
  output logic [WIDTH-1:0]    exp_val,
  output logic                mismatch,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [ERRCNT_W-1:0] chk_cnt,
  output logic [WIDTH-1:0]    first_exp,
  output logic [WIDTH-1:0]    first_obs,
  output logic                tracking,
  output logic                halted
);

  logic [1:0]       state;
  logic [WIDTH-1:0] nxt_exp;
  logic [WIDTH-1:0] nxt_obs;
  logic             diff;

  // Prediction from our own expectation.
  counter_model #(.WIDTH(WIDTH), .PL_WIDTH(PL_WIDTH)) u_pred_exp (
    .cur     (exp_val),
    .enable  (enable),
    .updn    (updn),
    .preload (preload),
    .pl_data (pl_data),
    .nxt     (nxt_exp)
  );

  // Prediction from the observed value, used to resync after a fault so a
  // single counter glitch is reported once instead of every cycle after.
  counter_model #(.WIDTH(WIDTH), .PL_WIDTH(PL_WIDTH)) u_pred_obs (
    .cur     (cout),
    .enable  (enable),
    .updn    (updn),
    .preload (preload),
    .pl_data (pl_data),
    .nxt     (nxt_obs)
  );

  assign diff     = (cout != exp_val);
  assign tracking = (state == ST_TRACK);
  assign halted   = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_SYNC;
      exp_val   <= '0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      first_exp <= '0;
      first_obs <= '0;
    end else if (state == ST_HALT) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= diff;
      if (chk_cnt != '1)
        chk_cnt <= chk_cnt + ERRCNT_W'(1);
      if (diff) begin
        if (err_cnt == '0) begin
          first_exp <= exp_val;
          first_obs <= cout;
        end
        if (err_cnt != '1)
          err_cnt <= err_cnt + ERRCNT_W'(1);
      end
      // SYNC always moves on to TRACK; only a TRACK mismatch may halt or
      // resync. On halt exp_val keeps the value that failed.
      if (state == ST_TRACK && diff && STOP_ON_ERR) begin
        state <= ST_HALT;
      end else begin
        state   <= ST_TRACK;
        exp_val <= (state == ST_TRACK && diff) ? nxt_obs : nxt_exp;
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       updn = 1'b1;
  logic       preload = 1'b0;
  logic [3:0] pl_data = 4'd0;
  logic [7:0] cout = 8'd0;

  logic [7:0]  exp_val0, first_exp0, first_obs0;
  logic [15:0] err_cnt0, chk_cnt0;
  logic        mismatch0, tracking0, halted0;
  logic [7:0]  exp_val1, first_exp1, first_obs1;
  logic [15:0] err_cnt1, chk_cnt1;
  logic        mismatch1, tracking1, halted1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(8), .PL_WIDTH(4), .ERRCNT_W(16), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .updn(updn), .preload(preload),
    .pl_data(pl_data), .cout(cout), .exp_val(exp_val0), .mismatch(mismatch0),
    .err_cnt(err_cnt0), .chk_cnt(chk_cnt0), .first_exp(first_exp0),
    .first_obs(first_obs0), .tracking(tracking0), .halted(halted0)
  );

  counter_checker #(.WIDTH(8), .PL_WIDTH(4), .ERRCNT_W(16), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .updn(updn), .preload(preload),
    .pl_data(pl_data), .cout(cout), .exp_val(exp_val1), .mismatch(mismatch1),
    .err_cnt(err_cnt1), .chk_cnt(chk_cnt1), .first_exp(first_exp1),
    .first_obs(first_obs1), .tracking(tracking1), .halted(halted1)
  );

  // Reference model, index 0 = resync variant, index 1 = stop-on-error variant.
  int m_exp[2], m_err[2], m_chk[2], m_fexp[2], m_fobs[2];
  bit m_mis[2], m_started[2], m_stopped[2];
  int ctr = 0; // a correctly behaving counter

  function automatic int predict(int base, bit en, bit ud, bit pl, int pd);
    if (pl) return pd;
    if (en) return ud ? (base + 1) % 256 : (base + 255) % 256;
    return base;
  endfunction

  task automatic step(input bit rst, input bit en, input bit ud, input bit pl,
                      input int pd, input int co);
    reset = rst; enable = en; updn = ud; preload = pl;
    pl_data = 4'(pd); cout = 8'(co);
    for (int i = 0; i < 2; i++) begin
      bit bad;
      if (rst) begin
        m_exp[i] = 0; m_err[i] = 0; m_chk[i] = 0; m_fexp[i] = 0; m_fobs[i] = 0;
        m_mis[i] = 0; m_started[i] = 0; m_stopped[i] = 0;
      end else if (m_stopped[i]) begin
        m_mis[i] = 0;
      end else begin
        bad = (co != m_exp[i]);
        m_mis[i] = bad;
        if (m_chk[i] < 65535) m_chk[i]++;
        if (bad) begin
          if (m_err[i] == 0) begin m_fexp[i] = m_exp[i]; m_fobs[i] = co; end
          if (m_err[i] < 65535) m_err[i]++;
        end
        if (bad && m_started[i] && i == 1) m_stopped[i] = 1;
        else begin
          m_exp[i] = predict((bad && m_started[i]) ? co : m_exp[i], en, ud, pl, pd);
          m_started[i] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit en, input bit ud, input bit pl, input int pd);
    step(1'b0, en, ud, pl, pd, ctr);
    ctr = predict(ctr, en, ud, pl, pd);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    ctr = 0;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if ({exp_val0, mismatch0, err_cnt0, chk_cnt0, first_exp0, first_obs0, tracking0, halted0} !== '0) begin
      errors++;
      $display("FAIL reset_dut0: got exp=%h mis=%b err=%0d chk=%0d fe=%h fo=%h trk=%b hlt=%b, want all zero",
               exp_val0, mismatch0, err_cnt0, chk_cnt0, first_exp0, first_obs0, tracking0, halted0);
    end
    checks++;
    if ({exp_val1, mismatch1, err_cnt1, chk_cnt1, first_exp1, first_obs1, tracking1, halted1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got exp=%h mis=%b err=%0d chk=%0d trk=%b hlt=%b, want all zero",
               exp_val1, mismatch1, err_cnt1, chk_cnt1, tracking1, halted1);
    end
  endtask

  task automatic test_up_count();
    for (int i = 0; i < 26; i++) begin
      run(1'b1, 1'b1, 1'b0, 0);
      checks++;
      if (exp_val0 !== 8'(m_exp[0]) || mismatch0 !== 1'b0) begin
        errors++;
        $display("FAIL up_count[%0d]: exp_val=%h mismatch=%b, want %h 0", i, exp_val0, mismatch0, 8'(m_exp[0]));
      end
    end
    checks++;
    if (exp_val0 !== 8'd26 || err_cnt0 !== 16'd0 || chk_cnt0 !== 16'd26 || tracking0 !== 1'b1) begin
      errors++;
      $display("FAIL up_count_end: exp=%0d err=%0d chk=%0d trk=%b, want 26 0 26 1",
               exp_val0, err_cnt0, chk_cnt0, tracking0);
    end
  endtask

  task automatic test_preload();
    run(1'b1, 1'b1, 1'b1, 5);
    checks++;
    if (exp_val0 !== 8'd5) begin
      errors++; $display("FAIL preload_5: exp_val=%h, want 05", exp_val0);
    end
    run(1'b1, 1'b1, 1'b0, 0);
    checks++;
    if (mismatch0 !== 1'b0 || exp_val0 !== 8'd6) begin
      errors++; $display("FAIL preload_accept: mismatch=%b exp_val=%h, want 0 06", mismatch0, exp_val0);
    end
    run(1'b1, 1'b1, 1'b1, 2);
    checks++;
    if (exp_val0 !== 8'd2 || exp_val1 !== 8'd2) begin
      errors++; $display("FAIL preload_priority: exp_val=%h/%h, want 02", exp_val0, exp_val1);
    end
  endtask

  task automatic test_wrap();
    int up_seq[3] = '{8'hFF, 8'h00, 8'h01};
    int dn_seq[2] = '{8'h00, 8'hFF};
    run(1'b1, 1'b1, 1'b1, 0);
    run(1'b1, 1'b0, 1'b0, 0);
    run(1'b1, 1'b0, 1'b0, 0);
    checks++;
    if (exp_val0 !== 8'hFE) begin
      errors++; $display("FAIL wrap_setup: exp_val=%h, want fe", exp_val0);
    end
    for (int i = 0; i < 3; i++) begin
      run(1'b1, 1'b1, 1'b0, 0);
      checks++;
      if (exp_val0 !== 8'(up_seq[i]) || mismatch0 !== 1'b0) begin
        errors++; $display("FAIL wrap_up[%0d]: exp_val=%h mismatch=%b, want %h 0", i, exp_val0, mismatch0, 8'(up_seq[i]));
      end
    end
    for (int i = 0; i < 2; i++) begin
      run(1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (exp_val0 !== 8'(dn_seq[i]) || mismatch0 !== 1'b0) begin
        errors++; $display("FAIL wrap_down[%0d]: exp_val=%h mismatch=%b, want %h 0", i, exp_val0, mismatch0, 8'(dn_seq[i]));
      end
    end
    checks++;
    if (err_cnt0 !== 16'd0 || err_cnt1 !== 16'd0) begin
      errors++; $display("FAIL wrap_err: err_cnt=%0d/%0d, want 0", err_cnt0, err_cnt1);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      run(1'b0, 1'($urandom), 1'b0, int'($urandom_range(0, 15)));
      checks++;
      if (exp_val0 !== 8'hFF || mismatch0 !== 1'b0 || err_cnt0 !== 16'd0) begin
        errors++; $display("FAIL hold[%0d]: exp_val=%h mismatch=%b err=%0d, want ff 0 0", i, exp_val0, mismatch0, err_cnt0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      run(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
      checks++;
      if (exp_val0 !== 8'(m_exp[0]) || exp_val1 !== 8'(m_exp[1]) || mismatch0 !== 1'b0 ||
          err_cnt0 !== 16'd0 || chk_cnt0 !== 16'(m_chk[0])) begin
        errors++;
        $display("FAIL random[%0d]: exp=%h/%h mis=%b err=%0d chk=%0d, want %h/%h 0 0 %0d", i,
                 exp_val0, exp_val1, mismatch0, err_cnt0, chk_cnt0, 8'(m_exp[0]), 8'(m_exp[1]), m_chk[0]);
      end
    end
  endtask

  task automatic test_fault_resync();
    for (int i = 0; i < 300 && ctr != 8'h3C; i++) run(1'b1, 1'b1, 1'b0, 0);
    checks++;
    if (exp_val0 !== 8'h3C) begin
      errors++; $display("FAIL fault_setup: exp_val=%h, want 3c", exp_val0);
    end
    ctr = 8'h40; // counter jumps
    run(1'b1, 1'b1, 1'b0, 0);
    checks++;
    if (mismatch0 !== 1'b1 || err_cnt0 !== 16'd1 || first_exp0 !== 8'h3C || first_obs0 !== 8'h40) begin
      errors++;
      $display("FAIL fault_capture: mis=%b err=%0d fe=%h fo=%h, want 1 1 3c 40", mismatch0, err_cnt0, first_exp0, first_obs0);
    end
    checks++;
    if (exp_val0 !== 8'h41 || tracking0 !== 1'b1) begin
      errors++; $display("FAIL fault_resync: exp_val=%h tracking=%b, want 41 1", exp_val0, tracking0);
    end
    checks++;
    if (halted1 !== 1'b1 || tracking1 !== 1'b0 || err_cnt1 !== 16'd1 || mismatch1 !== 1'b1) begin
      errors++; $display("FAIL fault_halt: halted=%b tracking=%b err=%0d mis=%b, want 1 0 1 1", halted1, tracking1, err_cnt1, mismatch1);
    end
    for (int i = 0; i < 5; i++) begin
      run(1'b1, 1'b1, 1'b0, 0);
      checks++;
      if (mismatch0 !== 1'b0 || err_cnt0 !== 16'd1 || chk_cnt0 !== 16'(m_chk[0])) begin
        errors++; $display("FAIL fault_after[%0d]: mis=%b err=%0d chk=%0d, want 0 1 %0d", i, mismatch0, err_cnt0, chk_cnt0, m_chk[0]);
      end
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      checks++;
      if (halted1 !== 1'b1 || mismatch1 !== 1'b0 || err_cnt1 !== 16'd1 || chk_cnt1 !== 16'(m_chk[1])) begin
        errors++; $display("FAIL halt_frozen[%0d]: hlt=%b mis=%b err=%0d chk=%0d, want 1 0 1 %0d",
                           i, halted1, mismatch1, err_cnt1, chk_cnt1, m_chk[1]);
      end
      checks++;
      if (err_cnt0 !== 16'(m_err[0]) || mismatch0 !== m_mis[0]) begin
        errors++; $display("FAIL halt_dut0[%0d]: err=%0d mis=%b, want %0d %b", i, err_cnt0, mismatch0, m_err[0], m_mis[0]);
      end
    end
    do_reset(1);
    checks++;
    if ({exp_val1, mismatch1, err_cnt1, chk_cnt1, first_exp1, first_obs1, tracking1, halted1} !== '0 ||
        {exp_val0, err_cnt0, chk_cnt0, first_exp0, first_obs0, tracking0} !== '0) begin
      errors++; $display("FAIL halt_reset: hlt=%b err=%0d/%0d chk=%0d/%0d fe=%h, want all zero",
                         halted1, err_cnt0, err_cnt1, chk_cnt0, chk_cnt1, first_exp1);
    end
  endtask

  task automatic test_first_edge();
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1);
    checks++;
    if (mismatch0 !== 1'b1 || err_cnt0 !== 16'd1 || tracking0 !== 1'b1 || first_obs0 !== 8'h01 || first_exp0 !== 8'h00) begin
      errors++; $display("FAIL first_edge_dut0: mis=%b err=%0d trk=%b fo=%h fe=%h, want 1 1 1 01 00",
                         mismatch0, err_cnt0, tracking0, first_obs0, first_exp0);
    end
    checks++;
    if (mismatch1 !== 1'b1 || err_cnt1 !== 16'd1 || tracking1 !== 1'b1 || halted1 !== 1'b0 || exp_val1 !== 8'h01) begin
      errors++; $display("FAIL first_edge_dut1: mis=%b err=%0d trk=%b hlt=%b exp=%h, want 1 1 1 0 01",
                         mismatch1, err_cnt1, tracking1, halted1, exp_val1);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 70000; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, m_exp[0] ^ 1);
      if (i % 5000 == 0 || i == 65533) begin
        checks++;
        if (err_cnt0 !== 16'(m_err[0]) || mismatch0 !== 1'b1) begin
          errors++; $display("FAIL sat_progress[%0d]: err=%0d mis=%b, want %0d 1", i, err_cnt0, mismatch0, m_err[0]);
        end
      end
    end
    checks++;
    if (err_cnt0 !== 16'hFFFF || chk_cnt0 !== 16'hFFFF || mismatch0 !== 1'b1) begin
      errors++; $display("FAIL saturation: err=%h chk=%h mis=%b, want ffff ffff 1", err_cnt0, chk_cnt0, mismatch0);
    end
    checks++;
    if (first_exp0 !== 8'h00 || first_obs0 !== 8'h01 || err_cnt1 !== 16'd2 || halted1 !== 1'b1) begin
      errors++; $display("FAIL sat_first_hold: fe=%h fo=%h err1=%0d hlt1=%b, want 00 01 2 1",
                         first_exp0, first_obs0, err_cnt1, halted1);
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_preload();
    test_wrap();
    test_hold();
    test_random();
    test_fault_resync();
    test_halt();
    test_first_edge();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
